div_ctrl: RTL

- EX-stage sequencer for the shared multi-cycle radix-2 divider.
- Detects a DIV/DIVU in EX and issues the start/annul handshake to the divider with stable operands.
- Stalls the pipeline until the divider finishes, then buffers the 64-bit result so a back-end stall never re-issues the division.
- Writes HI/LO exactly once when the instruction leaves EX; aborts cleanly on flush; a watchdog aborts a hung divider.

---
 rtl/div_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the shared multi-cycle radix-2 divider.
// Issues start/annul, stalls EX, buffers the result and writes HI/LO once.
module div_ctrl #(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid_i,
  input  logic        ex_div_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_op1_i,
  input  logic [31:0] ex_op2_i,
  input  logic        ex_hold_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_req_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        res_q;
  logic               req;

  assign req = ex_valid_i & ex_div_i & ~flush;

  // Sequencer: issue, wait for ready/flush/watchdog, hold result until EX leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      res_q        <= '0;
      div_start_o  <= 1'b0;
      div_annul_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      timeout_o    <= 1'b0;
    end else begin
      div_annul_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            div_op1_o    <= ex_op1_i;
            div_op2_o    <= ex_op2_i;
            div_signed_o <= ex_signed_i;
            div_start_o  <= 1'b1;
            cnt          <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (flush) begin
            div_start_o <= 1'b0;
            div_annul_o <= 1'b1;
            state       <= IDLE;
          end else if (div_ready_i) begin
            res_q       <= div_result_i;
            div_start_o <= 1'b0;
            state       <= DONE;
          end else if (cnt == CNT_LAST) begin
            div_start_o <= 1'b0;
            div_annul_o <= 1'b1;
            timeout_o   <= 1'b1;
            res_q       <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (flush || !ex_hold_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall EX while a division is being decoded or is in flight
  always_comb begin
    stall_req_o = 1'b0;
    unique case (state)
      IDLE:    stall_req_o = req;
      BUSY:    stall_req_o = 1'b1;
      DONE:    stall_req_o = 1'b0;
      default: stall_req_o = 1'b0;
    endcase
  end

  assign hilo_we_o = (state == DONE) & ~ex_hold_i & ~flush;
  assign hi_o      = res_q[63:32];
  assign lo_o      = res_q[31:0];

endmodule
